// File: rtl/alu_issue_unit.sv
// Issue sequencer for the ArithmeticLogicUnit: takes one request, drives the ALU,
// captures result/flags, evaluates a branch condition and returns a response.
module alu_issue_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [3:0]       ReqOp,
    input  logic             ReqWide,
    input  logic             ReqSetFlags,
    input  logic [15:0]      ReqA,
    input  logic [15:0]      ReqB,
    input  logic [2:0]       ReqCond,
    output logic [4:0]       FunSel,
    output logic [15:0]      AluA,
    output logic [15:0]      AluB,
    output logic             AluWF,
    input  logic [15:0]      AluOut,
    input  logic [3:0]       AluFlags,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [15:0]      RspResult,
    output logic [3:0]       RspFlags,
    output logic             RspCondTrue,
    output logic [CNT_W-1:0] OpCount
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

    localparam logic [4:0] FUNSEL_IDLE = 5'b10000;

    state_t     state;
    logic       wide_q;
    logic       set_flags_q;
    logic [2:0] cond_q;
    logic [3:0] shadow;
    logic [3:0] next_flags;
    logic       next_cond;

    // Flags are packed {Z,C,N,O} in bits [3:0].
    function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] flags);
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags[3];
            3'b010:  cond_true = ~flags[3];
            3'b011:  cond_true = flags[2];
            3'b100:  cond_true = ~flags[2];
            3'b101:  cond_true = flags[1];
            3'b110:  cond_true = flags[0];
            default: cond_true = 1'b0;
        endcase
    endfunction

    // The condition must see the flags this op reports, not the previous response.
    always_comb begin
        next_flags = set_flags_q ? AluFlags : shadow;
        next_cond  = cond_true(cond_q, next_flags);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            ReqReady    <= 1'b1;
            RspValid    <= 1'b0;
            RspResult   <= '0;
            RspFlags    <= '0;
            RspCondTrue <= 1'b0;
            FunSel      <= FUNSEL_IDLE;
            AluA        <= '0;
            AluB        <= '0;
            AluWF       <= 1'b0;
            shadow      <= '0;
            OpCount     <= '0;
            wide_q      <= 1'b0;
            set_flags_q <= 1'b0;
            cond_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        wide_q      <= ReqWide;
                        set_flags_q <= ReqSetFlags;
                        cond_q      <= ReqCond;
                        FunSel      <= {ReqWide, ReqOp};
                        AluA        <= ReqA;
                        AluB        <= ReqB;
                        AluWF       <= ReqSetFlags;
                        ReqReady    <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    AluWF <= 1'b0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    RspResult   <= wide_q ? AluOut : {8'h00, AluOut[7:0]};
                    RspFlags    <= next_flags;
                    RspCondTrue <= next_cond;
                    if (set_flags_q) begin
                        shadow <= AluFlags;
                    end
                    RspValid <= 1'b1;
                    FunSel   <= FUNSEL_IDLE;
                    state    <= RESPOND;
                end
                RESPOND: begin
                    if (RspReady) begin
                        if (OpCount != '1) begin
                            OpCount <= OpCount + CNT_W'(1);
                        end
                        RspValid <= 1'b0;
                        ReqReady <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small behavioural ALU model attached.
module tb_alu_issue_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [3:0]  ReqOp;
    logic        ReqWide;
    logic        ReqSetFlags;
    logic [15:0] ReqA;
    logic [15:0] ReqB;
    logic [2:0]  ReqCond;
    logic [4:0]  FunSel;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic        AluWF;
    logic [15:0] AluOut;
    logic [3:0]  AluFlags;
    logic        RspValid;
    logic        RspReady;
    logic [15:0] RspResult;
    logic [3:0]  RspFlags;
    logic        RspCondTrue;
    logic [1:0]  OpCount;

    int checks = 0;
    int errors = 0;

    alu_issue_unit #(.CNT_W(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqWide(ReqWide),
        .ReqSetFlags(ReqSetFlags), .ReqA(ReqA), .ReqB(ReqB), .ReqCond(ReqCond),
        .FunSel(FunSel), .AluA(AluA), .AluB(AluB), .AluWF(AluWF),
        .AluOut(AluOut), .AluFlags(AluFlags),
        .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult),
        .RspFlags(RspFlags), .RspCondTrue(RspCondTrue), .OpCount(OpCount)
    );

    always #5 Clock = ~Clock;

    // Behavioural ALU: 0000 pass A, 0100 add, 0111 and, 1000 or; flags {Z,C,N,O}.
    logic [16:0] sum16;
    logic [8:0]  sum8;
    logic [3:0]  alu_flags_next;
    always_comb begin
        sum16 = {1'b0, AluA} + {1'b0, AluB};
        sum8  = {1'b0, AluA[7:0]} + {1'b0, AluB[7:0]};
        case (FunSel[3:0])
            4'b0000: AluOut = AluA;
            4'b0100: AluOut = sum16[15:0];
            4'b0111: AluOut = AluA & AluB;
            4'b1000: AluOut = AluA | AluB;
            default: AluOut = 16'h0000;
        endcase
        if (FunSel[4]) begin
            alu_flags_next[3] = (AluOut == 16'h0000);
            alu_flags_next[2] = (FunSel[3:0] == 4'b0100) && sum16[16];
            alu_flags_next[1] = AluOut[15];
            alu_flags_next[0] = (FunSel[3:0] == 4'b0100) && (AluA[15] == AluB[15]) && (AluOut[15] != AluA[15]);
        end else begin
            alu_flags_next[3] = (AluOut[7:0] == 8'h00);
            alu_flags_next[2] = (FunSel[3:0] == 4'b0100) && sum8[8];
            alu_flags_next[1] = AluOut[7];
            alu_flags_next[0] = (FunSel[3:0] == 4'b0100) && (AluA[7] == AluB[7]) && (AluOut[7] != AluA[7]);
        end
    end

    initial AluFlags = 4'b0000;
    always @(posedge Clock) if (AluWF) AluFlags <= alu_flags_next;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic wide, input logic sf,
                                 input logic [15:0] a, input logic [15:0] b, input logic [2:0] cond);
        ReqOp       = op;
        ReqWide     = wide;
        ReqSetFlags = sf;
        ReqA        = a;
        ReqB        = b;
        ReqCond     = cond;
        ReqValid    = 1'b1;
    endtask

    // Full transaction from IDLE back to IDLE with checks at every phase.
    task automatic doOp(input string tag, input logic [3:0] op, input logic wide, input logic sf,
                        input logic [15:0] a, input logic [15:0] b, input logic [2:0] cond,
                        input logic [15:0] exp_result, input logic [3:0] exp_flags,
                        input logic exp_cond, input logic [1:0] exp_count);
        checkOutput({tag, "_idle_ready"}, 16'(ReqReady), 16'h1);
        applyStimulus(op, wide, sf, a, b, cond);
        tick();
        ReqValid = 1'b0;
        checkOutput({tag, "_issue_funsel"}, 16'(FunSel), 16'({wide, op}));
        checkOutput({tag, "_issue_wf"}, 16'(AluWF), 16'(sf));
        checkOutput({tag, "_issue_a"}, AluA, a);
        checkOutput({tag, "_issue_b"}, AluB, b);
        checkOutput({tag, "_issue_ready"}, 16'(ReqReady), 16'h0);
        tick();
        checkOutput({tag, "_capture_wf"}, 16'(AluWF), 16'h0);
        checkOutput({tag, "_capture_funsel"}, 16'(FunSel), 16'({wide, op}));
        checkOutput({tag, "_capture_valid"}, 16'(RspValid), 16'h0);
        tick();
        checkOutput({tag, "_rsp_valid"}, 16'(RspValid), 16'h1);
        checkOutput({tag, "_rsp_result"}, RspResult, exp_result);
        checkOutput({tag, "_rsp_flags"}, 16'(RspFlags), 16'(exp_flags));
        checkOutput({tag, "_rsp_cond"}, 16'(RspCondTrue), 16'(exp_cond));
        checkOutput({tag, "_rsp_funsel"}, 16'(FunSel), 16'h10);
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
        checkOutput({tag, "_done_valid"}, 16'(RspValid), 16'h0);
        checkOutput({tag, "_done_ready"}, 16'(ReqReady), 16'h1);
        checkOutput({tag, "_done_count"}, 16'(OpCount), 16'(exp_count));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        ReqValid = 1'b0; ReqOp = '0; ReqWide = 1'b0; ReqSetFlags = 1'b0;
        ReqA = '0; ReqB = '0; ReqCond = '0; RspReady = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        checkOutput("rst_ready", 16'(ReqReady), 16'h1);
        checkOutput("rst_valid", 16'(RspValid), 16'h0);
        checkOutput("rst_result", RspResult, 16'h0);
        checkOutput("rst_flags", 16'(RspFlags), 16'h0);
        checkOutput("rst_cond", 16'(RspCondTrue), 16'h0);
        checkOutput("rst_funsel", 16'(FunSel), 16'h10);
        checkOutput("rst_alua", AluA, 16'h0);
        checkOutput("rst_alub", AluB, 16'h0);
        checkOutput("rst_wf", 16'(AluWF), 16'h0);
        checkOutput("rst_count", 16'(OpCount), 16'h0);

        // Stray RspReady in IDLE must not count anything
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
        checkOutput("stray_ready_count", 16'(OpCount), 16'h0);
        checkOutput("stray_ready_valid", 16'(RspValid), 16'h0);

        // Reset during CAPTURE of a flag-setting add: op dropped, shadow stays clear
        applyStimulus(4'b0100, 1'b0, 1'b1, 16'h00FF, 16'h0001, 3'b001);
        tick();
        ReqValid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("midrst_valid", 16'(RspValid), 16'h0);
        checkOutput("midrst_ready", 16'(ReqReady), 16'h1);
        checkOutput("midrst_count", 16'(OpCount), 16'h0);
        checkOutput("midrst_funsel", 16'(FunSel), 16'h10);
        tick();
        checkOutput("midrst_no_rsp", 16'(RspValid), 16'h0);
        doOp("midrst_shadow", 4'b1000, 1'b1, 1'b0, 16'h1200, 16'h0034, 3'b001,
             16'h1234, 4'b0000, 1'b0, 2'd1);

        // 8-bit add with carry out of the low byte; upper byte must be dropped
        doOp("add8", 4'b0100, 1'b0, 1'b1, 16'h00FF, 16'h0001, 3'b001,
             16'h0000, 4'b1100, 1'b1, 2'd2);
        // 16-bit OR without flag update reports the shadow flags
        doOp("or16", 4'b1000, 1'b1, 1'b0, 16'h1200, 16'h0034, 3'b010,
             16'h1234, 4'b1100, 1'b0, 2'd3);

        // Backpressure: response held while a new request waits
        applyStimulus(4'b0100, 1'b1, 1'b1, 16'h1234, 16'h1111, 3'b000);
        tick();
        ReqValid = 1'b0;
        tick();
        tick();
        applyStimulus(4'b0100, 1'b0, 1'b1, 16'h00FF, 16'h00FF, 3'b000);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 16'(RspValid), 16'h1);
            checkOutput("bp_result", RspResult, 16'h2345);
            checkOutput("bp_flags", 16'(RspFlags), 16'h0);
            checkOutput("bp_cond", 16'(RspCondTrue), 16'h1);
            checkOutput("bp_ready", 16'(ReqReady), 16'h0);
            checkOutput("bp_funsel", 16'(FunSel), 16'h10);
            tick();
        end
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
        checkOutput("bp_release_valid", 16'(RspValid), 16'h0);
        checkOutput("bp_release_ready", 16'(ReqReady), 16'h1);
        checkOutput("bp_sat_count", 16'(OpCount), 16'h3);
        tick();
        ReqValid = 1'b0;
        checkOutput("bp_next_funsel", 16'(FunSel), 16'h04);
        checkOutput("bp_next_alua", AluA, 16'h00FF);
        tick();
        tick();
        // FF+FF in 8 bits gives FE with carry and negative: flags 0110
        checkOutput("sweep_set_result", RspResult, 16'h00FE);
        checkOutput("sweep_set_flags", 16'(RspFlags), 16'h6);
        checkOutput("sweep_set_cond", 16'(RspCondTrue), 16'h1);
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
        checkOutput("sweep_set_count", 16'(OpCount), 16'h3);

        // Remaining condition codes against shadow flags 0110
        doOp("cond001", 4'b1000, 1'b0, 1'b0, 16'h0012, 16'h0034, 3'b001, 16'h0036, 4'b0110, 1'b0, 2'd3);
        doOp("cond010", 4'b1000, 1'b0, 1'b0, 16'h0012, 16'h0034, 3'b010, 16'h0036, 4'b0110, 1'b1, 2'd3);
        doOp("cond011", 4'b1000, 1'b0, 1'b0, 16'h0012, 16'h0034, 3'b011, 16'h0036, 4'b0110, 1'b1, 2'd3);
        doOp("cond100", 4'b1000, 1'b0, 1'b0, 16'h0012, 16'h0034, 3'b100, 16'h0036, 4'b0110, 1'b0, 2'd3);
        doOp("cond101", 4'b1000, 1'b0, 1'b0, 16'h0012, 16'h0034, 3'b101, 16'h0036, 4'b0110, 1'b1, 2'd3);
        doOp("cond110", 4'b1000, 1'b0, 1'b0, 16'h0012, 16'h0034, 3'b110, 16'h0036, 4'b0110, 1'b0, 2'd3);
        doOp("cond111", 4'b1000, 1'b0, 1'b0, 16'h0012, 16'h0034, 3'b111, 16'h0036, 4'b0110, 1'b0, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Front-end sequencer that sits between the instruction control path and the ArithmeticLogicUnit.
- Accepts one ALU operation request at a time over a valid/ready handshake and drives FunSel, A, B and WF to the ALU.
- Waits for the ALU's clocked flag update, then captures the result and flags.
- Evaluates a branch condition against those flags and returns a response over a second valid/ready handshake. It also keeps a shadow flag register and a completed-operation counter.

Parameters:
- CNT_W, 16, width of the completed-operation counter OpCount (saturating).

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- ReqValid  in  1  request valid
- ReqReady  out  1  request accepted when ReqValid&ReqReady
- ReqOp  in  4  ALU operation code, FunSel[3:0]
- ReqWide  in  1  1 = 16-bit op, 0 = 8-bit op; FunSel[4]
- ReqSetFlags  in  1  op updates architectural flags
- ReqA  in  16  operand A
- ReqB  in  16  operand B
- ReqCond  in  3  condition select for RspCondTrue
- FunSel  out  5  to ALU
- AluA  out  16  to ALU A
- AluB  out  16  to ALU B
- AluWF  out  1  to ALU WF
- AluOut  in  16  ALU result, combinational from FunSel/A/B
- AluFlags  in  4  ALU FlagsOut {Z,C,N,O} = [3:0], updated on rising Clock
- RspValid  out  1  response valid
- RspReady  in  1  response consumed when RspValid&RspReady
- RspResult  out  16  captured ALU result; upper byte zeroed for 8-bit ops
- RspFlags  out  4  flags reported for this op
- RspCondTrue  out  1  evaluated condition
- OpCount  out  CNT_W  completed responses, saturates at all-ones

Behaviour:
- FSM states: IDLE, ISSUE, CAPTURE, RESPOND. Reset forces IDLE from any state, including mid-op; the in-flight op is dropped and no response is produced.
- Reset values: ReqReady=1, RspValid=0, RspResult=0, RspFlags=0, RspCondTrue=0, FunSel=5'b10000, AluA=0, AluB=0, AluWF=0, shadow flags=4'b0000, OpCount=0.
- IDLE: ReqReady=1. On ReqValid, register Op/Wide/SetFlags/A/B/Cond, go to ISSUE. ReqReady=0 in every other state.
- ISSUE (1 cycle): FunSel={Wide,Op}, AluA/AluB=registered operands, AluWF=SetFlags. The ALU latches flags at the end of this cycle. Go to CAPTURE.
- CAPTURE (1 cycle): FunSel/AluA/AluB are held; AluWF=0.
  - Register RspResult=AluOut (8-bit op: {8'h00,AluOut[7:0]}).
  - If SetFlags: RspFlags=AluFlags and shadow is updated to AluFlags. Otherwise RspFlags=shadow, unchanged.
  - Compute RspCondTrue from the new RspFlags value. Go to RESPOND.
- RESPOND: RspValid=1 with all Rsp* outputs stable. When RspReady is sampled high, increment OpCount (no increment at all-ones), clear RspValid and go to IDLE.
- Latency: accept at edge N, RspValid high from cycle N+3. Minimum issue interval is 4 cycles. A request presented while RspValid=1 is not accepted until IDLE.
- Outside ISSUE/CAPTURE: FunSel=5'b10000, AluWF=0, AluA/AluB hold last values.
- Condition codes:
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 C
  - 100 !C
  - 101 N
  - 110 O
  - 111 never
- ReqValid deasserted while in IDLE causes no state change. Request inputs are ignored outside IDLE.
- RspReady high while RspValid=0 has no effect.

Test Plan:
- 8-bit add: Op=4'b0100, Wide=0, SetFlags=1, A=16'h00FF, B=16'h0001, Cond=001 -> FunSel=5'b00100 in the ISSUE cycle, AluWF=1. RspValid at N+3 with RspResult=16'h0000, RspFlags[3]=1 (Z), RspFlags[2]=1 (C), RspCondTrue=1, OpCount becomes 1 on RspReady.
- SetFlags=0 after the add above: 16-bit OR, Op=4'b1000, Wide=1, A=16'h1200, B=16'h0034, Cond=010 -> RspResult=16'h1234, RspFlags equals the previous shadow value (Z=1), RspCondTrue=0, AluWF=0 throughout.
- Backpressure: hold RspReady=0 for 5 cycles with ReqValid=1 and new operands -> RspValid stays 1, Rsp* stable, ReqReady=0, FunSel=5'b10000. Release -> next op accepted one cycle after the handshake.
- Reset mid-op: assert Reset in the CAPTURE cycle -> next cycle IDLE, RspValid=0, ReqReady=1, OpCount unchanged, shadow=4'b0000.
- Counter saturation with CNT_W=2 -> after 5 completed ops OpCount=2'b11.
- Condition sweep: fix the flags at {Z,C,N,O}=4'b0110 and run Cond=000..111 -> RspCondTrue=1,0,1,1,0,1,0,0.
